// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi output-selection stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package viterbi_pkg;

    localparam int NUM_STATES  = 4;
    localparam int PM_W        = 7;
    localparam int SURV_W      = 8;
    localparam int NORM_THRESH = 64;

    // Index of one trellis state (00..11).
    typedef logic [$clog2(NUM_STATES)-1:0] state_idx_t;

endpackage

// File: rtl/viterbi_bit_fifo.sv
// Single-bit FIFO holding decoded bits, with a sticky overflow flag.
// Latency: push at edge n is visible on head_o/empty_o after edge n; no bypass.
// Backpressure: push on full without a pop is dropped and sets overflow_o.
//
// Ports: clk, rst (async, active-high); push_i/push_dat_i write side;
//        pop_i read strobe (ignored when empty); head_o oldest bit (0 when
//        empty); full_o, empty_o status; overflow_o sticky drop flag.
module viterbi_bit_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic push_dat_i,
    input  logic pop_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o,
    output logic overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DEPTH-1:0] mem_q,      mem_d;
    logic [PW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic             overflow_q, overflow_d;

    logic do_pop;
    logic do_push;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop on full frees the slot the simultaneous push needs.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat_i;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_i && !do_push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign head_o     = empty_o ? 1'b0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow_o = overflow_q;

endmodule

// File: rtl/viterbi_out_sel.sv
// Picks the minimum-metric trellis state each step and emits its oldest survivor bit.
// Latency: in_valid edge n -> FIFO write edge n+1 -> out_valid after n+1 (if empty).
// Backpressure: out_valid/out_ready; bits arriving on a full FIFO are dropped (sticky overflow).
//
// Ports: clk, rst (async, active-high); in_valid, pm_0..pm_3, surv_0..surv_3
//        trellis step input; out_valid/out_ready/out_bit decoded stream;
//        best_state, pm_min registered winner; overflow sticky drop flag;
//        norm_req metric-normalisation request (only with VITERBI_PM_NORM_EN).
// Optional feature macro: VITERBI_PM_NORM_EN.
module viterbi_out_sel
    import viterbi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WARMUP     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PM_W-1:0]   pm_0,
    input  logic [PM_W-1:0]   pm_1,
    input  logic [PM_W-1:0]   pm_2,
    input  logic [PM_W-1:0]   pm_3,
    input  logic [SURV_W-1:0] surv_0,
    input  logic [SURV_W-1:0] surv_1,
    input  logic [SURV_W-1:0] surv_2,
    input  logic [SURV_W-1:0] surv_3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic [1:0]        best_state,
    output logic [PM_W-1:0]   pm_min,
    output logic              overflow
`ifdef VITERBI_PM_NORM_EN
    ,
    output logic              norm_req
`endif
);

    localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(WARMUP);

    logic [PM_W-1:0]   pm_arr   [NUM_STATES];
    logic [SURV_W-1:0] surv_arr [NUM_STATES];

    state_idx_t      sel_idx;
    logic [PM_W-1:0] sel_pm;
    logic            sel_bit;

    state_idx_t      best_state_q, best_state_d;
    logic [PM_W-1:0] pm_min_q,     pm_min_d;
    logic            dec_q,        dec_d;
    logic            s1_vld_q,     s1_vld_d;
    logic [CNT_W-1:0] warm_q,      warm_d;

    logic fifo_full;
    logic fifo_empty;

    // Only the oldest survivor bit feeds the decision; the rest is consumed upstream.
    logic unused_surv;
    assign unused_surv = ^{surv_0[SURV_W-2:0], surv_1[SURV_W-2:0],
                           surv_2[SURV_W-2:0], surv_3[SURV_W-2:0], fifo_full};

    assign pm_arr[0]   = pm_0;
    assign pm_arr[1]   = pm_1;
    assign pm_arr[2]   = pm_2;
    assign pm_arr[3]   = pm_3;
    assign surv_arr[0] = surv_0;
    assign surv_arr[1] = surv_1;
    assign surv_arr[2] = surv_2;
    assign surv_arr[3] = surv_3;

    // Strict less-than keeps the earlier (lower-index) state on ties.
    always_comb begin
        sel_idx = '0;
        sel_pm  = pm_arr[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_arr[i] < sel_pm) begin
                sel_pm  = pm_arr[i];
                sel_idx = state_idx_t'(i);
            end
        end
        sel_bit = surv_arr[sel_idx][SURV_W-1];
    end

    // S1: capture the winner. The bit is kept only once the warmup count has
    // saturated, so the first WARMUP accepted steps never reach the FIFO.
    always_comb begin
        best_state_d = best_state_q;
        pm_min_d     = pm_min_q;
        dec_d        = dec_q;
        s1_vld_d     = 1'b0;
        warm_d       = warm_q;
        if (in_valid) begin
            best_state_d = sel_idx;
            pm_min_d     = sel_pm;
            dec_d        = sel_bit;
            s1_vld_d     = (warm_q == WARM_MAX);
            if (warm_q != WARM_MAX) begin
                warm_d = warm_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_state_q <= '0;
            pm_min_q     <= '0;
            dec_q        <= 1'b0;
            s1_vld_q     <= 1'b0;
            warm_q       <= '0;
        end else begin
            best_state_q <= best_state_d;
            pm_min_q     <= pm_min_d;
            dec_q        <= dec_d;
            s1_vld_q     <= s1_vld_d;
            warm_q       <= warm_d;
        end
    end

    viterbi_bit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (s1_vld_q),
        .push_dat_i (dec_q),
        .pop_i      (out_ready),
        .head_o     (out_bit),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (overflow)
    );

    assign out_valid  = !fifo_empty;
    assign best_state = best_state_q;
    assign pm_min     = pm_min_q;

`ifdef VITERBI_PM_NORM_EN
    // Registered off pm_min so the request follows the captured winner by one edge.
    logic norm_req_q, norm_req_d;

    always_comb begin
        norm_req_d = (pm_min_q >= PM_W'(NORM_THRESH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            norm_req_q <= 1'b0;
        end else begin
            norm_req_q <= norm_req_d;
        end
    end

    assign norm_req = norm_req_q;
`endif

endmodule

// File: tb/tb_viterbi_out_sel.sv
module tb_viterbi_out_sel;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [6:0] pm_0, pm_1, pm_2, pm_3;
    logic [7:0] surv_0, surv_1, surv_2, surv_3;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic [1:0] best_state;
    logic [6:0] pm_min;
    logic       overflow;
`ifdef VITERBI_PM_NORM_EN
    logic       norm_req;
`endif

    int checks = 0;
    int errors = 0;

    viterbi_out_sel #(
        .FIFO_DEPTH (4),
        .WARMUP     (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .pm_0       (pm_0),
        .pm_1       (pm_1),
        .pm_2       (pm_2),
        .pm_3       (pm_3),
        .surv_0     (surv_0),
        .surv_1     (surv_1),
        .surv_2     (surv_2),
        .surv_3     (surv_3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .best_state (best_state),
        .pm_min     (pm_min),
        .overflow   (overflow)
`ifdef VITERBI_PM_NORM_EN
        ,
        .norm_req   (norm_req)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted trellis step: inputs applied after a falling edge, captured
    // on the next rising edge; returns at the following falling edge.
    task automatic drive_step(input logic [6:0] a, input logic [6:0] b,
                              input logic [6:0] c, input logic [6:0] d,
                              input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        pm_0 = a; pm_1 = b; pm_2 = c; pm_3 = d;
        surv_0 = s0; surv_1 = s1; surv_2 = s2; surv_3 = s3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // State 0 wins; losers carry the opposite bit so a wrong pick shows up.
    task automatic step_bit(input logic b);
        drive_step(7'd0, 7'd10, 7'd10, 7'd10,
                   {b, 7'h00}, {~b, 7'h7f}, {~b, 7'h7f}, {~b, 7'h7f});
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_bit !== 1'b0) begin errors++; $display("FAIL rst_out_bit got %b want 0", out_bit); end
        checks++; if (best_state !== 2'd0) begin errors++; $display("FAIL rst_best_state got %0d want 0", best_state); end
        checks++; if (pm_min !== 7'd0) begin errors++; $display("FAIL rst_pm_min got %0d want 0", pm_min); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_warmup();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step_bit(1'b1);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL warmup_step%0d_out_valid got %b want 0", i, out_valid); end
        end
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL warmup_first_valid got %b want 1", out_valid); end
        checks++; if (out_bit !== 1'b1) begin errors++; $display("FAIL warmup_first_bit got %b want 1", out_bit); end
        out_ready = 1'b1;
        idle();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL warmup_only_one got %b want 0", out_valid); end
    endtask

    task automatic test_select();
        out_ready = 1'b0;
        drive_step(7'd5, 7'd3, 7'd3, 7'd9, 8'h00, 8'h80, 8'h00, 8'h00);
        checks++; if (best_state !== 2'd1) begin errors++; $display("FAIL tie_best_state got %0d want 1", best_state); end
        checks++; if (pm_min !== 7'd3) begin errors++; $display("FAIL tie_pm_min got %0d want 3", pm_min); end
        drive_step(7'd9, 7'd9, 7'd9, 7'd9, 8'h80, 8'h00, 8'h00, 8'h00);
        checks++; if (best_state !== 2'd0) begin errors++; $display("FAIL alltie_best_state got %0d want 0", best_state); end
        checks++; if (pm_min !== 7'd9) begin errors++; $display("FAIL alltie_pm_min got %0d want 9", pm_min); end
        drive_step(7'd20, 7'd15, 7'd30, 7'd2, 8'h00, 8'h00, 8'h00, 8'h80);
        checks++; if (best_state !== 2'd3) begin errors++; $display("FAIL last_best_state got %0d want 3", best_state); end
        checks++; if (pm_min !== 7'd2) begin errors++; $display("FAIL last_pm_min got %0d want 2", pm_min); end
        pm_0 = 7'd0; pm_1 = 7'd0; pm_2 = 7'd0; pm_3 = 7'd0;
        idle();
        idle();
        checks++; if (best_state !== 2'd3) begin errors++; $display("FAIL hold_best_state got %0d want 3", best_state); end
        checks++; if (pm_min !== 7'd2) begin errors++; $display("FAIL hold_pm_min got %0d want 2", pm_min); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin errors++; $display("FAIL select_bit%0d got vld=%b bit=%b want vld=1 bit=1", k, out_valid, out_bit); end
            idle();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL select_drained got %b want 0", out_valid); end
    endtask

    task automatic test_empty_push_pop();
        out_ready = 1'b1;
        step_bit(1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_pp_capture got %b want 0", out_valid); end
        idle();
        checks++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin errors++; $display("FAIL empty_pp_stored got vld=%b bit=%b want vld=1 bit=1", out_valid, out_bit); end
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_pp_popped got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic exp_bits [4];
        exp_bits[0] = 1'b1; exp_bits[1] = 1'b0; exp_bits[2] = 1'b1; exp_bits[3] = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) step_bit(exp_bits[k]);
        idle();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got %b want 0", overflow); end
        checks++; if (out_bit !== 1'b1) begin errors++; $display("FAIL ovf_stall_head got %b want 1", out_bit); end
        step_bit(1'b0);
        idle();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_bit !== exp_bits[k]) begin errors++; $display("FAIL ovf_read%0d got vld=%b bit=%b want vld=1 bit=%b", k, out_valid, out_bit, exp_bits[k]); end
            idle();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped got vld=%b want 0", out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic fill [4];
        logic exp_bits [4];
        fill[0] = 1'b1; fill[1] = 1'b1; fill[2] = 1'b0; fill[3] = 1'b1;
        exp_bits[0] = 1'b1; exp_bits[1] = 1'b0; exp_bits[2] = 1'b1; exp_bits[3] = 1'b0;
        out_ready = 1'b0;
        pulse_reset();
        for (int i = 0; i < 7; i++) step_bit(1'b1);
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_warm got %b want 0", out_valid); end
        for (int k = 0; k < 4; k++) step_bit(fill[k]);
        step_bit(1'b0);
        // The fifth bit is pushed on the next edge, together with this pop.
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin errors++; $display("FAIL fpp_head got vld=%b bit=%b want vld=1 bit=1", out_valid, out_bit); end
        idle();
        out_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_no_overflow got %b want 0", overflow); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_bit !== exp_bits[k]) begin errors++; $display("FAIL fpp_read%0d got vld=%b bit=%b want vld=1 bit=%b", k, out_valid, out_bit, exp_bits[k]); end
            idle();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_count got vld=%b want 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        step_bit(1'b1); step_bit(1'b0); step_bit(1'b1); step_bit(1'b1); step_bit(1'b1);
        idle();
        out_ready = 1'b1;
        idle();
        out_ready = 1'b0;
        checks++; if (overflow !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got ovf=%b vld=%b want ovf=1 vld=1", overflow, out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b want 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_async_overflow got %b want 0", overflow); end
        checks++; if (out_bit !== 1'b0) begin errors++; $display("FAIL mid_async_bit got %b want 0", out_bit); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step_bit(1'b1);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_warm%0d got %b want 0", i, out_valid); end
        end
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_warm_done got %b want 0", out_valid); end
        step_bit(1'b1);
        idle();
        checks++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin errors++; $display("FAIL mid_first_kept got vld=%b bit=%b want vld=1 bit=1", out_valid, out_bit); end
        out_ready = 1'b1;
        idle();
        out_ready = 1'b0;
    endtask

`ifdef VITERBI_PM_NORM_EN
    task automatic test_norm();
        out_ready = 1'b1;
        drive_step(7'd63, 7'd70, 7'd70, 7'd70, 8'h00, 8'h00, 8'h00, 8'h00);
        idle();
        checks++; if (norm_req !== 1'b0) begin errors++; $display("FAIL norm_63 got %b want 0", norm_req); end
        drive_step(7'd64, 7'd70, 7'd70, 7'd70, 8'h00, 8'h00, 8'h00, 8'h00);
        checks++; if (norm_req !== 1'b0) begin errors++; $display("FAIL norm_64_early got %b want 0", norm_req); end
        idle();
        checks++; if (norm_req !== 1'b1) begin errors++; $display("FAIL norm_64 got %b want 1", norm_req); end
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        pm_0 = '0; pm_1 = '0; pm_2 = '0; pm_3 = '0;
        surv_0 = '0; surv_1 = '0; surv_2 = '0; surv_3 = '0;
        test_reset();
        test_warmup();
        test_select();
        test_empty_push_pop();
        test_overflow();
        test_full_push_pop();
        test_reset_midstream();
`ifdef VITERBI_PM_NORM_EN
        test_norm();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/viterbi_out_sel.md
VITERBI_OUT_SEL -- requirements
Module: viterbi_out_sel

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter WARMUP, default 7, number of initial accepted trellis steps whose output is discarded.
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  one trellis step of PM/survivor data present this cycle.
REQ-006 SHALL have ports pm_0..pm_3  input  7 each  path metrics of states 00..11 from the ACS_mem stage.
REQ-007 SHALL have ports surv_0..surv_3  input  8 each  survivor registers of states 00..11; bit 7 oldest.
REQ-008 SHALL have port out_valid  output  1  out_bit holds a decoded bit.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_bit when out_valid && out_ready.
REQ-010 SHALL have port out_bit  output  1  decoded bit, oldest first.
REQ-011 SHALL have ports best_state  output  2, and pm_min  output  7  registered winner of the last accepted step.
REQ-012 SHALL have port overflow  output  1  sticky: a decoded bit was dropped.

Function
REQ-013 SHALL on each edge with in_valid=1 select the state with the minimum pm_x; ties resolve to the lowest state index.
REQ-014 SHALL register at that edge best_state, pm_min, and the decision bit = surv_<best>[7] (stage S1).
REQ-015 SHALL keep a warmup counter, 0..WARMUP, incremented per accepted step and saturating at WARMUP.
REQ-016 SHALL mark an S1 bit as discardable while the counter is below WARMUP when it is sampled; the 8th accepted step after reset yields the first kept bit.
REQ-017 SHALL push a kept S1 bit into the FIFO on the edge following its capture (latency: in_valid edge n -> FIFO write edge n+1 -> out_valid at n+1 if FIFO was empty).
REQ-018 SHALL present the FIFO head on out_bit with out_valid=1 whenever the FIFO is non-empty; out_bit SHALL be stable while out_valid && !out_ready.
REQ-019 SHALL pop on out_valid && out_ready.
REQ-020 SHALL, when a push and a pop coincide on a full FIFO, accept both (count unchanged).
REQ-021 SHALL, when a push occurs on a full FIFO without a pop, drop the new bit, leave FIFO contents unchanged and set overflow to 1 until reset.
REQ-022 SHALL, when a push and pop coincide on an empty FIFO, not bypass: pop is impossible since out_valid=0; the bit is stored.
REQ-023 SHALL use wrapping read/write pointers of log2(FIFO_DEPTH)+1 bits; full = MSBs differ and LSBs equal.
REQ-024 SHALL hold best_state/pm_min when in_valid=0 and SHALL not push in the following cycle.

Reset
REQ-025 SHALL on rst=1 asynchronously clear: out_valid=0, out_bit=0, best_state=0, pm_min=0, overflow=0, FIFO pointers, S1 valid, warmup counter.
REQ-026 SHALL, on reset asserted mid-stream, discard all buffered bits and restart the warmup count after release.

Configuration
REQ-027 SHALL, when macro VITERBI_PM_NORM_EN is defined, provide output norm_req  1  registered high when pm_min >= 64 (bit 6 set), telling the ACS stage to subtract 64 from all metrics; reset value 0.
REQ-028 SHALL, without VITERBI_PM_NORM_EN, omit port norm_req and all its logic.

Structure
REQ-029 SHALL place NUM_STATES=4, PM_W=7, SURV_W=8, NORM_THRESH=64 and the state-index typedef in shared package viterbi_pkg.
REQ-030 SHALL implement the buffer as sub-module viterbi_bit_fifo (push, pop, full, empty, sticky overflow); the min-select stays inline.

Verification
REQ-031 SHALL cover: pm=(5,3,3,9), surv_1=8'h80 -> best_state=1, pm_min=3, decision bit 1 (tie to lower index).
REQ-032 SHALL cover: reset, then 8 consecutive valid steps with winning surv[7]=1 -> first 7 bits discarded, exactly one out_bit=1 with out_valid at edge 9.
REQ-033 SHALL cover: out_ready=0, 4 kept bits 1,0,1,1 then a 5th -> overflow=1, subsequent reads return 1,0,1,1 only.
REQ-034 SHALL cover: full FIFO, simultaneous push and pop -> no overflow, count stays 4, order preserved.
REQ-035 SHALL cover: rst pulsed while FIFO holds 3 bits -> out_valid=0 immediately (async), overflow=0, next 7 steps discarded.
REQ-036 SHALL cover (VITERBI_PM_NORM_EN): minimum pm 63 -> norm_req=0; minimum pm 64 -> norm_req=1 one edge later.
